// File: rtl/branch_sequencer.sv
// Conditional-branch sequencer for the T3..T6 control steps of a branch instruction.
// Once a start request carrying the branch opcode is accepted, the block walks
// T3 -> T4 -> T5 -> T6 -> DONE -> IDLE, one cycle per state. In each state it
// drives that state's datapath controls. It also records the branch outcome
// and keeps saturating counts of taken and not-taken branches.
//
// Ports:
//   clock, clear            clock; synchronous active-high reset
//   start, ir               request to execute ir; accepted only in IDLE
//   con_out                 CON flip-flop result, sampled when leaving T3
//   c2                      registered C2 condition field (ir[20:19])
//   gra, rout, con_in       T3 controls
//   pc_out, y_in            T4 controls
//   c_out, add_op, z_in     T5 controls
//   zlo_out, pc_in          T6 controls (pc_in only when the branch is taken)
//   busy, done, taken       status; done/taken valid in DONE only
//   illegal                 one-cycle pulse after a start with a non-branch opcode
//   taken_cnt, nottaken_cnt saturating outcome counters
module branch_sequencer #(
  parameter logic [4:0]  BR_OPCODE = 5'b10010,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic [31:0]      ir,
  input  logic             con_out,
  output logic [1:0]       c2,
  output logic             gra,
  output logic             rout,
  output logic             con_in,
  output logic             pc_out,
  output logic             y_in,
  output logic             c_out,
  output logic             add_op,
  output logic             z_in,
  output logic             zlo_out,
  output logic             pc_in,
  output logic             busy,
  output logic             done,
  output logic             taken,
  output logic             illegal,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nottaken_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T3   = 3'd1,
    S_T4   = 3'd2,
    S_T5   = 3'd3,
    S_T6   = 3'd4,
    S_DONE = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic [1:0]       c2_q, c2_d;
  logic             con_q, con_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
  logic [CNT_W-1:0] nottaken_cnt_q, nottaken_cnt_d;

  // Next-state and register updates
  always_comb begin
    state_d        = state_q;
    c2_d           = c2_q;
    con_d          = con_q;
    illegal_d      = 1'b0;
    taken_cnt_d    = taken_cnt_q;
    nottaken_cnt_d = nottaken_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (ir[31:27] == BR_OPCODE) begin
            state_d = S_T3;
            c2_d    = ir[20:19];
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      S_T3: begin
        state_d = S_T4;
        con_d   = con_out;
      end
      S_T4: state_d = S_T5;
      S_T5: state_d = S_T6;
      S_T6: begin
        // Counters update on the edge into DONE, so they are current while done=1.
        state_d = S_DONE;
        if (con_q) begin
          if (taken_cnt_q != '1) taken_cnt_d = taken_cnt_q + CNT_ONE;
        end else begin
          if (nottaken_cnt_q != '1) nottaken_cnt_d = nottaken_cnt_q + CNT_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q        <= S_IDLE;
      c2_q           <= '0;
      con_q          <= 1'b0;
      illegal_q      <= 1'b0;
      taken_cnt_q    <= '0;
      nottaken_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      c2_q           <= c2_d;
      con_q          <= con_d;
      illegal_q      <= illegal_d;
      taken_cnt_q    <= taken_cnt_d;
      nottaken_cnt_q <= nottaken_cnt_d;
    end
  end

  // Moore output decode
  always_comb begin
    gra     = 1'b0;
    rout    = 1'b0;
    con_in  = 1'b0;
    pc_out  = 1'b0;
    y_in    = 1'b0;
    c_out   = 1'b0;
    add_op  = 1'b0;
    z_in    = 1'b0;
    zlo_out = 1'b0;
    pc_in   = 1'b0;
    done    = 1'b0;
    taken   = 1'b0;
    unique case (state_q)
      S_T3: begin
        gra    = 1'b1;
        rout   = 1'b1;
        con_in = 1'b1;
      end
      S_T4: begin
        pc_out = 1'b1;
        y_in   = 1'b1;
      end
      S_T5: begin
        c_out  = 1'b1;
        add_op = 1'b1;
        z_in   = 1'b1;
      end
      S_T6: begin
        zlo_out = 1'b1;
        pc_in   = con_q;
      end
      S_DONE: begin
        done  = 1'b1;
        taken = con_q;
      end
      default: ;
    endcase
  end

  assign busy         = (state_q != S_IDLE);
  assign c2           = c2_q;
  assign illegal      = illegal_q;
  assign taken_cnt    = taken_cnt_q;
  assign nottaken_cnt = nottaken_cnt_q;

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 Parameter BR_OPCODE, default 5'b10010, opcode (ir[31:27]) identifying a conditional branch.
REQ-002 Parameter CNT_W, default 16, width of taken/not-taken counters.
REQ-003 clock  in  1  single clock, all state updates on rising edge.
REQ-004 clear  in  1  reset, synchronous and active-high.
REQ-005 start  in  1  request to execute the instruction held on ir; accepted only in IDLE.
REQ-006 ir  in  32  instruction register contents; ir[20:19]=C2 condition code.
REQ-007 con_out  in  1  condition result from the CON flip-flop, valid during T3.
REQ-008 c2  out  2  registered C2 field driven to the CON flip-flop decoder.
REQ-009 gra, rout, con_in  out  1 each  T3 controls: select Ra, drive Ra to bus, enable CON evaluation.
REQ-010 pc_out, y_in  out  1 each  T4 controls: PC to bus, load Y.
REQ-011 c_out, add_op, z_in  out  1 each  T5 controls: sign-extended C to bus, ALU add, load Z.
REQ-012 zlo_out, pc_in  out  1 each  T6 controls: Zlow to bus, load PC.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 done  out  1  one-cycle completion pulse.
REQ-015 taken  out  1  branch outcome, valid while done=1.
REQ-016 illegal  out  1  one-cycle pulse: start with non-branch opcode.
REQ-017 taken_cnt, nottaken_cnt  out  CNT_W each  saturating outcome counters.

Function
REQ-018 States: IDLE, T3, T4, T5, T6, DONE; one-hot or encoded, exactly one active.
REQ-019 IDLE, start=1, ir[31:27]=BR_OPCODE -> T3 next cycle; c2 <= ir[20:19] on the same edge.
REQ-020 IDLE, start=1, opcode mismatch -> remain IDLE, illegal=1 for the next cycle, counters unchanged.
REQ-021 start while busy=1 ignored; ir changes while busy ignored (c2 held).
REQ-022 T3->T4->T5->T6->DONE->IDLE unconditionally, one cycle each; start-to-done latency 5 cycles.
REQ-023 Each control output high only in its own state per REQ-009..012, all others 0.
REQ-024 con_q register samples con_out on the edge leaving T3; con_out ignored in all other states.
REQ-025 In T6 pc_in=con_q; zlo_out=1 regardless of con_q.
REQ-026 In DONE done=1, taken=con_q; taken=0 outside DONE.
REQ-027 On entry to DONE: con_q=1 increments taken_cnt, else nottaken_cnt; saturates at 2^CNT_W-1, no wrap.
REQ-028 Start accepted in IDLE on the cycle immediately after DONE (back-to-back: done then T3 two cycles apart).

Reset
REQ-029 clear=1 at a rising edge: state=IDLE, c2=0, con_q=0, both counters 0, all control outputs, busy, done, taken, illegal 0 next cycle.
REQ-030 clear overrides start and any in-progress sequence (mid-operation abort: no pc_in, no done, no counter update).
REQ-031 clear has priority over counter increment in the same cycle.

Verification
REQ-032 ir=0x9008_0014 (opcode 10010, C2=01), start pulse, con_out=1 in T3 -> cycles 1..4 show T3/T4/T5/T6 controls, pc_in=1 in T6, done=taken=1 in cycle 5, taken_cnt=1, c2=2'b01.
REQ-033 Same ir, con_out=0 in T3 and 1 in other cycles -> pc_in=0 in T6, done=1, taken=0, nottaken_cnt=1.
REQ-034 ir=0x0800_0000 (opcode 00001), start -> illegal=1 one cycle, busy stays 0, counters unchanged.
REQ-035 start held high during T4..DONE, ir changed to C2=11 mid-sequence -> single sequence, c2 stays 01; second sequence begins in cycle after DONE.
REQ-036 clear asserted in T5 -> next cycle IDLE, all outputs 0, no done, counters 0.
REQ-037 Preload by 65535 taken branches -> taken_cnt=0xFFFF; one more taken -> stays 0xFFFF.
